// File: rtl/fp4_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the FP4 multiplier arbiter.
package fp4_arb_pkg;

    localparam int FP4_W   = 4;
    localparam int FP4P_W  = 6;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Returns a one-hot grant for the first valid requester found when scanning
    // upward from ptr and wrapping at nreq-1. The vector is sized for the largest
    // supported requester count; the caller uses only the low nreq bits.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [2:0]         ptr,
                                                   input int                 nreq);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [3:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'(nreq)) begin
                    idx = idx - 4'(nreq);
                end
                if (!found && valid[idx[2:0]]) begin
                    grant[idx[2:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fp4_mul.sv
// Registered FP4 x FP4 multiplier. Inputs are {sign, exp[1:0], mant[0]} with
// bias 1; an exponent of 00 is treated as zero, so any such operand flushes the
// product to a signed zero. The product is {sign, exp[1:0], mant[2:0]}, bias 1,
// and magnitudes beyond the largest encodable value saturate to {sign, 5'b11111}.
module fp4_mul
    import fp4_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FP4_W-1:0]  a,
    input  logic [FP4_W-1:0]  b,
    output logic [FP4P_W-1:0] p
);

    logic              prodSign;
    logic              prodZero;
    logic [3:0]        sigProd;
    logic [2:0]        expSum;
    logic [2:0]        prodFrac;
    logic [FP4P_W-1:0] p_d;
    logic [FP4P_W-1:0] p_q;

    // Combinational product: multiply the two 2-bit significands (1.m), add
    // exponents, renormalise by one place when the significand product reaches 2.
    always_comb begin
        prodSign = a[3] ^ b[3];
        prodZero = (a[2:1] == 2'b00) || (b[2:1] == 2'b00);
        sigProd  = 4'({1'b1, a[0]}) * 4'({1'b1, b[0]});
        expSum   = {1'b0, a[2:1]} + {1'b0, b[2:1]} - 3'd1 + {2'b00, sigProd[3]};
        prodFrac = sigProd[3] ? sigProd[2:0] : {sigProd[1:0], 1'b0};
        p_d      = '0;
        if (prodZero) begin
            p_d = {prodSign, 5'b00000};
        end else if (expSum > 3'd3) begin
            p_d = {prodSign, 5'b11111};
        end else begin
            p_d = {prodSign, expSum[1:0], prodFrac};
        end
    end

    // Output register gives the block its one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/fp4_mul_arbiter.sv
// Round-robin arbiter sharing one registered fp4_mul between NREQ requesters.
// Products return one cycle after the transfer, tagged with the requester ID.
// Build option FP4_ARB_BURST_EN: a requester may lock the multiplier for a
// burst of up to MAX_BURST beats, ended early by req_last.
module fp4_mul_arbiter
    import fp4_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ID_W      = $clog2(NREQ),
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [FP4_W*NREQ-1:0] req_a,
    input  logic [FP4_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]       req_last,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [FP4P_W-1:0]     rsp_data,
    output logic                  busy
);

    logic [ID_W-1:0]    rr_ptr_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [MAX_REQ-1:0] validPad;
    logic [MAX_REQ-1:0] pickWide;
    logic [NREQ-1:0]    grant;
    logic               xfer;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    ptrNext;
    logic [FP4_W-1:0]   mulA;
    logic [FP4_W-1:0]   mulB;

`ifdef FP4_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q;
    logic [ID_W-1:0]  owner_q;
    logic [CNT_W-1:0] burst_cnt_q;
`endif

    // Grant selection: round-robin scan in ARB, owner-only while a burst holds
    // the multiplier; nothing is granted while reset is asserted.
    always_comb begin
        validPad             = '0;
        validPad[NREQ-1:0]   = req_valid;
        pickWide             = rr_pick(validPad, 3'(rr_ptr_q), NREQ);
        grant                = '0;
        if (rst_n) begin
`ifdef FP4_ARB_BURST_EN
            if (state_q == LOCK) begin
                if (req_valid[owner_q]) begin
                    grant[owner_q] = 1'b1;
                end
            end else begin
                grant = pickWide[NREQ-1:0];
            end
`else
            grant = pickWide[NREQ-1:0];
`endif
        end
    end

    if (NREQ < MAX_REQ) begin : g_pickHi
        logic unusedPickHi;
        assign unusedPickHi = ^pickWide[MAX_REQ-1:NREQ];
    end

    // One-hot operand mux; with no grant the multiplier sees zeros so an idle
    // cycle always produces a zero product.
    always_comb begin
        winner = '0;
        mulA   = '0;
        mulB   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                winner = ID_W'(i);
                mulA   = req_a[FP4_W*i +: FP4_W];
                mulB   = req_b[FP4_W*i +: FP4_W];
            end
        end
    end

    assign xfer      = |grant;
    assign req_ready = grant;
    assign ptrNext   = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);

    // Response tag pipeline and round-robin pointer. The pointer moves past the
    // winner on every transfer; inside a burst the winner is always the owner,
    // so on release it already points at owner+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= xfer;
            rsp_id_q    <= winner;
            if (xfer) begin
                rr_ptr_q <= ptrNext;
            end
        end
    end

`ifdef FP4_ARB_BURST_EN
    // Burst FSM: an ARB transfer without last locks onto the winner; the lock
    // ends on an owner beat with last or when the beat limit is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else if (xfer) begin
            case (state_q)
                ARB: begin
                    if (!req_last[winner]) begin
                        state_q     <= LOCK;
                        owner_q     <= winner;
                        burst_cnt_q <= CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (req_last[winner] || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_q     <= ARB;
                        burst_cnt_q <= '0;
                    end else begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ARB;
                end
            endcase
        end
    end

    assign busy = rsp_valid_q | (state_q == LOCK);
`else
    logic unusedCfg;
    assign unusedCfg = (^req_last) ^ (MAX_BURST > 0);
    assign busy      = rsp_valid_q;
`endif

    fp4_mul u_mul (
        .clk (clk),
        .rst (~rst_n),
        .a   (mulA),
        .b   (mulB),
        .p   (rsp_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_fp4_mul_arbiter.sv
// Bench for fp4_mul_arbiter: a directed vector table, randomized traffic against
// a behavioural model, and burst corner sequences when FP4_ARB_BURST_EN is set.
module tb_fp4_mul_arbiter;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int MAX_BURST = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [15:0]     req_a;
    logic [15:0]     req_b;
    logic [NREQ-1:0] req_last;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [5:0]      rsp_data;
    logic            busy;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state: pointer, lock, and the response due after the next edge.
    int         mPtr;
    bit         mLocked;
    int         mOwner;
    int         mBeats;
    bit         mRspValid;
    int         mRspId;
    logic [5:0] mRspData;

    typedef struct {
        logic        rstn;
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  expReady;
        logic        expRspValid;
        logic        chkId;
        logic [1:0]  expRspId;
        logic [5:0]  expRspData;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    fp4_mul_arbiter #(
        .NREQ      (NREQ),
        .ID_W      (ID_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Real value of an FP4 operand; exponent 00 counts as zero.
    function automatic real fp4Val(input logic [3:0] x);
        real v;
        if (x[2:1] == 2'b00) return 0.0;
        v = x[0] ? 1.5 : 1.0;
        for (int k = 1; k < int'(x[2:1]); k++) v = v * 2.0;
        return v;
    endfunction

    // Product encoded as {sign, exp[1:0], frac[2:0]}, bias 1, saturating.
    function automatic logic [5:0] fpMulRef(input logic [3:0] a, input logic [3:0] b);
        real  mag;
        logic s;
        int   e;
        int   frac;
        mag = fp4Val(a) * fp4Val(b);
        s   = a[3] ^ b[3];
        if (mag == 0.0) return {s, 5'b00000};
        e = 1;
        while (mag >= 2.0) begin
            mag = mag / 2.0;
            e++;
        end
        if (e > 3) return {s, 5'b11111};
        frac = int'((mag - 1.0) * 8.0);
        return {s, 2'(e), 3'(frac)};
    endfunction

    function automatic logic [3:0] modelGrant();
        logic [3:0] g;
        int         idx;
        g = 4'b0000;
        if (!rst_n) return g;
        if (mLocked) begin
            if (req_valid[mOwner]) g[mOwner] = 1'b1;
            return g;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (mPtr + k) % NREQ;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Compare all outputs against the model after inputs have settled.
    task automatic checkOutput(input string tag);
        checkValue({tag, " ready"}, 32'(req_ready), 32'(modelGrant()));
        checkValue({tag, " rsp_valid"}, 32'(rsp_valid), 32'(mRspValid));
        checkValue({tag, " rsp_data"}, 32'(rsp_data), 32'(mRspData));
        checkValue({tag, " busy"}, 32'(busy), 32'(mRspValid || mLocked));
        if (mRspValid) checkValue({tag, " rsp_id"}, 32'(rsp_id), 32'(mRspId));
    endtask

    task automatic modelReset();
        mPtr      = 0;
        mLocked   = 1'b0;
        mOwner    = 0;
        mBeats    = 0;
        mRspValid = 1'b0;
        mRspId    = 0;
        mRspData  = 6'b000000;
    endtask

    // Advance the model across the coming clock edge.
    task automatic modelAdvance();
        logic [3:0] g;
        int         w;
        g = modelGrant();
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (g == 4'b0000) begin
            mRspValid = 1'b0;
            mRspData  = 6'b000000;
            return;
        end
        w = 0;
        for (int k = 0; k < NREQ; k++) if (g[k]) w = k;
        mRspValid = 1'b1;
        mRspId    = w;
        mRspData  = fpMulRef(req_a[4*w +: 4], req_b[4*w +: 4]);
`ifdef FP4_ARB_BURST_EN
        if (mLocked) begin
            mBeats++;
            if (req_last[w] || mBeats == MAX_BURST) begin
                mLocked = 1'b0;
                mBeats  = 0;
                mPtr    = (w + 1) % NREQ;
            end
        end else begin
            mPtr = (w + 1) % NREQ;
            if (!req_last[w]) begin
                mLocked = 1'b1;
                mOwner  = w;
                mBeats  = 1;
            end
        end
`else
        mPtr = (w + 1) % NREQ;
`endif
    endtask

    // Drive one cycle of inputs on the falling edge, check, then step the model.
    task automatic applyStimulus(input logic rstn, input logic [3:0] valid, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] last);
        @(negedge clk);
        rst_n     = rstn;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        req_last  = last;
        #1;
        checkOutput("model");
        modelAdvance();
    endtask

    task automatic burstStep(input string name, input logic [3:0] valid, input logic [3:0] last,
                             input logic [3:0] expReady);
        applyStimulus(1'b1, valid, 16'h935A, 16'h3322, last);
        checkValue(name, 32'(req_ready), 32'(expReady));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '1;
        modelReset();
        repeat (2) @(posedge clk);

        // Operands: 935A/3322 -> r0 -1.0*1.0, r1 3.0*1.0, r2 1.5*1.5, r3 subnormal*1.5
        //           9359/3323 -> r0 subnormal*1.5, others unchanged
        vecs[0]  = '{1'b0, 4'b1111, 16'h935A, 16'h3322, 4'b0000, 1'b0, 1'b1, 2'd0, 6'b000000};
        vecs[1]  = '{1'b1, 4'b1111, 16'h935A, 16'h3322, 4'b0001, 1'b0, 1'b1, 2'd0, 6'b000000};
        vecs[2]  = '{1'b1, 4'b1111, 16'h935A, 16'h3322, 4'b0010, 1'b1, 1'b1, 2'd0, 6'b101000};
        vecs[3]  = '{1'b1, 4'b1111, 16'h935A, 16'h3322, 4'b0100, 1'b1, 1'b1, 2'd1, 6'b010100};
        vecs[4]  = '{1'b1, 4'b1111, 16'h935A, 16'h3322, 4'b1000, 1'b1, 1'b1, 2'd2, 6'b010001};
        vecs[5]  = '{1'b1, 4'b1111, 16'h935A, 16'h3322, 4'b0001, 1'b1, 1'b1, 2'd3, 6'b100000};
        vecs[6]  = '{1'b1, 4'b0010, 16'h935A, 16'h3322, 4'b0010, 1'b1, 1'b1, 2'd0, 6'b101000};
        vecs[7]  = '{1'b1, 4'b0001, 16'h9359, 16'h3323, 4'b0001, 1'b1, 1'b1, 2'd1, 6'b010100};
        vecs[8]  = '{1'b1, 4'b0100, 16'h9359, 16'h3323, 4'b0100, 1'b1, 1'b1, 2'd0, 6'b100000};
        vecs[9]  = '{1'b1, 4'b1000, 16'h9359, 16'h3323, 4'b1000, 1'b1, 1'b1, 2'd2, 6'b010001};
        vecs[10] = '{1'b1, 4'b0000, 16'h9359, 16'h3323, 4'b0000, 1'b1, 1'b1, 2'd3, 6'b100000};
        vecs[11] = '{1'b1, 4'b0000, 16'h9359, 16'h3323, 4'b0000, 1'b0, 1'b0, 2'd0, 6'b000000};
        vecs[12] = '{1'b1, 4'b0000, 16'h9359, 16'h3323, 4'b0000, 1'b0, 1'b0, 2'd0, 6'b000000};
        vecs[13] = '{1'b1, 4'b1111, 16'h9359, 16'h3323, 4'b0001, 1'b0, 1'b0, 2'd0, 6'b000000};
        vecs[14] = '{1'b1, 4'b0000, 16'h9359, 16'h3323, 4'b0000, 1'b1, 1'b1, 2'd0, 6'b100000};
        vecs[15] = '{1'b1, 4'b0010, 16'h9359, 16'h3323, 4'b0010, 1'b0, 1'b0, 2'd0, 6'b000000};
        vecs[16] = '{1'b1, 4'b0000, 16'h9359, 16'h3323, 4'b0000, 1'b1, 1'b1, 2'd1, 6'b010100};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].valid, vecs[i].a, vecs[i].b, 4'b1111);
            checkValue($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            checkValue($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].expRspValid));
            checkValue($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].expRspData));
            if (vecs[i].chkId) begin
                checkValue($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].expRspId));
            end
        end

        // Randomized traffic with occasional resets and mostly-set last flags.
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000, 4'b1111);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom), 16'($urandom), 16'($urandom),
                          4'($urandom) | 4'($urandom));
        end

`ifdef FP4_ARB_BURST_EN
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000, 4'b1111);
        burstStep("t5 setup", 4'b0010, 4'b1111, 4'b0010);
        burstStep("t5a beat1", 4'b0101, 4'b1011, 4'b0100);
        burstStep("t5a beat2", 4'b0101, 4'b1011, 4'b0100);
        burstStep("t5a beat3", 4'b0101, 4'b1111, 4'b0100);
        burstStep("t5a after", 4'b0101, 4'b1111, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            burstStep($sformatf("t5b beat%0d", i + 1), 4'b1010, 4'b1101, 4'b0010);
        end
        burstStep("t5b release", 4'b1010, 4'b1101, 4'b1000);
        burstStep("t5b beat9", 4'b1010, 4'b1101, 4'b0010);
        burstStep("t5c stall1", 4'b0001, 4'b1101, 4'b0000);
        checkValue("t5c busy", 32'(busy), 32'd1);
        burstStep("t5c stall2", 4'b0001, 4'b1101, 4'b0000);
        burstStep("t5c last", 4'b0011, 4'b1111, 4'b0010);
        burstStep("t5c req0", 4'b0001, 4'b1111, 4'b0001);
        burstStep("t6 beat1", 4'b0100, 4'b1011, 4'b0100);
        applyStimulus(1'b0, 4'b0101, 16'h935A, 16'h3322, 4'b1011);
        checkValue("t6 reset ready", 32'(req_ready), 32'd0);
        burstStep("t6 rearb", 4'b0101, 4'b1111, 4'b0001);
        checkValue("t6 dropped rsp", 32'(rsp_valid), 32'd0);
        burstStep("t6 idle", 4'b0000, 4'b1111, 4'b0000);
        checkValue("t6 rsp_id", 32'(rsp_id), 32'd0);
`endif

        applyStimulus(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b1111);
        applyStimulus(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
